// File: rtl/shift_left_logical_seq.sv
// Multi-cycle logical left shifter: accepts an operand and shift amount over a
// valid/ready handshake, shifts one bit per clock, and presents result plus last bit out.
module shift_left_logical_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             carry_q, carry_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  // The edge that sees count==1 performs the final shift and lands in DONE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = a;
          count_d = shift;
          carry_d = 1'b0;
          state_d = (shift == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        carry_d = data_q[WIDTH-1];
        data_d  = {data_q[WIDTH-2:0], 1'b0};
        count_d = count_q - SHW'(1);
        if (count_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign out       = data_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Self-checking bench for shift_left_logical_seq: directed scenarios plus an
// exhaustive operand/shift sweep with random output stalls against an arithmetic model.
module tb_shift_left_logical_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [2:0] shift_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       carry;
  logic       busy;

  int checks = 0;
  int errors = 0;

  shift_left_logical_seq #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .shift     (shift_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the operand.
  function automatic logic [7:0] model_out(input int av, input int n);
    return 8'((av << n) & 255);
  endfunction

  function automatic logic model_carry(input int av, input int n);
    if (n == 0) return 1'b0;
    return 1'((av >> (8 - n)) & 1);
  endfunction

  // Issues one operation with out_ready held high and records what was seen.
  task automatic run_op(input logic [7:0] av, input logic [2:0] nv,
                        output logic acc, output int lat, output int busy_cnt,
                        output logic [7:0] ro, output logic rc);
    acc       = in_ready;
    a_in      = av;
    shift_in  = nv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    ro       = '0;
    rc       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_cnt++;
      if (out_valid && lat < 0) begin
        lat = i;
        ro  = out;
        rc  = carry;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a_in = 8'hFF; shift_in = 3'd3; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out, carry} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b busy=%b out=%h c=%b, want 1 0 0 00 0",
               in_ready, out_valid, busy, out, carry);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got rdy=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_shift3();
    logic acc, rc; int lat, bc; logic [7:0] ro;
    run_op(8'hB5, 3'd3, acc, lat, bc, ro, rc);
    checks++;
    if (acc !== 1'b1 || lat != 3 || bc != 4) begin
      errors++;
      $display("[TB] FAIL shift3_timing: got acc=%b lat=%0d busy=%0d, want 1 3 4", acc, lat, bc);
    end
    checks++;
    if (ro !== 8'hA8 || rc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL shift3_value: got out=%h c=%b, want a8 1", ro, rc);
    end
  endtask

  task automatic test_zero();
    logic acc, rc; int lat, bc; logic [7:0] ro;
    run_op(8'h3C, 3'd0, acc, lat, bc, ro, rc);
    checks++;
    if (acc !== 1'b1 || lat != 0 || bc != 1) begin
      errors++;
      $display("[TB] FAIL zero_timing: got acc=%b lat=%0d busy=%0d, want 1 0 1", acc, lat, bc);
    end
    checks++;
    if (ro !== 8'h3C || rc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_value: got out=%h c=%b, want 3c 0", ro, rc);
    end
  endtask

  task automatic test_max();
    logic acc, rc; int lat, bc; logic [7:0] ro;
    run_op(8'hFF, 3'd7, acc, lat, bc, ro, rc);
    checks++;
    if (lat != 7 || ro !== 8'h80 || rc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL max_ff: got lat=%0d out=%h c=%b, want 7 80 1", lat, ro, rc);
    end
    run_op(8'hFD, 3'd7, acc, lat, bc, ro, rc);
    checks++;
    if (lat != 7 || ro !== 8'h80 || rc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL max_fd: got lat=%0d out=%h c=%b, want 7 80 0", lat, ro, rc);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    a_in = 8'h0F; shift_in = 3'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("[TB] FAIL bp_latency: got %0d cycles, want 2", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a_in     = 8'h55;
      shift_in = 3'd1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out, carry} !== {1'b1, 1'b0, 8'h3C, 1'b0}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got vld=%b rdy=%b out=%h c=%b, want 1 0 3c 0",
                 i, out_valid, in_ready, out, carry);
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_accept: got busy=%b vld=%b, want 1 0", busy, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out !== 8'hAA || carry !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_pending: got vld=%b out=%h c=%b, want 1 aa 0", out_valid, out, carry);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic acc, rc; int lat, bc; logic [7:0] ro;
    out_ready = 1'b0;
    a_in = 8'hAA; shift_in = 3'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out, carry, in_ready, busy} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rst_mid: got vld=%b out=%h c=%b rdy=%b busy=%b, want 0 00 0 1 0",
               out_valid, out, carry, in_ready, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_discard: got busy=%b vld=%b, want 0 0", busy, out_valid);
    end
    run_op(8'h01, 3'd1, acc, lat, bc, ro, rc);
    checks++;
    if (acc !== 1'b1 || lat != 1 || ro !== 8'h02 || rc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_after: got acc=%b lat=%0d out=%h c=%b, want 1 1 02 0", acc, lat, ro, rc);
    end
  endtask

  task automatic test_exhaustive();
    int cyc;
    logic hs;
    logic [7:0] exp_o;
    logic exp_c;
    for (int av = 0; av < 256; av++) begin
      for (int n = 0; n < 8; n++) begin
        exp_o = model_out(av, n);
        exp_c = model_carry(av, n);
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ex_ready a=%h n=%0d: got rdy=%b, want 1", av[7:0], n, in_ready);
        end
        a_in = av[7:0]; shift_in = n[2:0]; in_valid = 1'b1;
        out_ready = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = 8'($urandom); shift_in = 3'($urandom);
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 60) begin
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            hs = 1'b1;
            checks++;
            if (out !== exp_o || carry !== exp_c) begin
              errors++;
              $display("[TB] FAIL ex_value a=%h n=%0d: got out=%h c=%b, want %h %b",
                       av[7:0], n, out, carry, exp_o, exp_c);
            end
          end
          @(posedge clk); #1;
          cyc++;
        end
        checks++;
        if (!hs || out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ex_once a=%h n=%0d: got hs=%b vld=%b rdy=%b, want 1 0 1",
                   av[7:0], n, hs, out_valid, in_ready);
        end
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; shift_in = '0;
    test_reset();
    test_shift3();
    test_zero();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_left_logical_seq.md
# shift_left_logical_seq

Multi-cycle logical left shifter for the KGP ALU datapath: the left-shift counterpart of the combinational logical right shifter. It accepts an operand and a shift amount over a valid/ready handshake and shifts one bit position per clock. It presents the result and the last bit shifted out over a second valid/ready handshake. It serves ALU sequencing where area matters more than single-cycle shift latency.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits.
- SHW, 3, shift-amount width; WIDTH = 2**SHW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/shift amount valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand, sampled on acceptance.
- shift  input  SHW  shift amount N, 0..WIDTH-1, sampled on acceptance.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  registered result, a << N, zero-filled from the LSB.
- carry  output  1  last bit shifted out: a[WIDTH-N] for N≥1, 0 for N=0.
- busy  output  1  high in SHIFT or DONE.

## Operation

- Three states: IDLE, SHIFT and DONE. Internal registers: data (WIDTH), count (SHW), carry (1).
- IDLE
  - in_ready=1.
  - On in_valid: data←a, count←shift, carry←0.
  - Next state is DONE if shift==0, otherwise SHIFT.
- SHIFT
  - Each clock: carry←data[WIDTH-1], data←{data[WIDTH-2:0],1'b0}, count←count-1.
  - When count==1 on an edge, that edge performs the final shift and moves to DONE.
- DONE
  - out_valid=1. out=data and carry are held stable.
  - On out_ready: next state is IDLE.
  - in_valid is ignored; no overlap of operations.
- out is driven from data at all times. out is only meaningful while out_valid=1.
- a and shift changes after acceptance have no effect.
- in_valid during SHIFT or DONE is ignored. The upstream holds it until in_ready.
- Reset values: state IDLE, data 0, count 0, carry 0, in_ready 1, out_valid 0, busy 0, out 0. Inputs are ignored while rst is high.
- Reset mid-operation (SHIFT or DONE): outputs go to reset values immediately (asynchronously). The in-flight result is discarded and never presented.
- All arithmetic is modulo-free. The shift amount is never wider than SHW, so no out-of-range case exists.

## Timing

- Acceptance edge E0 is the edge where in_valid & in_ready.
- out_valid rises after edge E_N (E0 when N=0):
  - N=0: out_valid is seen in the cycle after E0.
  - N=7: out_valid is seen 7 cycles after the N=0 case would be.
- Release: the edge with out_valid & out_ready returns to IDLE. in_ready is high in the following cycle.
- Back-to-back throughput: one operation per N+2 cycles (accept, N shifts, DONE, IDLE).
- in_ready, out_valid and busy are decoded directly from the state register, with no combinational path from inputs.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.

## Test plan

- Shift by 3: a=8'hB5, shift=3 → out_valid after E3, out=8'hA8, carry=1, busy high for the 4 cycles before release.
- Zero shift: a=8'h3C, shift=0 → out_valid in the cycle after E0, out=8'h3C, carry=0.
- Maximum shift: a=8'hFF, shift=7 → out=8'h80, carry=1, out_valid after E7. Repeat with a=8'hFD → out=8'h80, carry=0.
- Backpressure: complete a=8'h0F, shift=2, hold out_ready=0 for 5 cycles while pulsing in_valid with new data:
  - out=8'h3C, carry=0 and out_valid stay stable; in_ready stays 0; the new data is not accepted.
  - Raising out_ready → IDLE next cycle, then the pending in_valid is accepted.
- Reset mid-shift: a=8'hAA, shift=6, assert rst after E2 → out_valid=0, out=0, carry=0, in_ready=1 with no clock edge. After release, a=8'h01, shift=1 yields out=8'h02, carry=0.
- Exhaustive: all 256 operands × 8 shift amounts with random out_ready stalls → out == (a<<N)[7:0] and carry == a[8-N] (0 for N=0), and exactly one result per accepted input.
